pipelined_addsub: RTL and testbench

- Parametrised, pipelined add/subtract unit; successor to the team's single-cycle N-bit adder.
- Splits the N-bit operation into STAGES ripple segments, one per register stage, so wide adders close timing.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake on both sides with full back-pressure.
- Sits between operand producers (register file / datapath muxes) and a result consumer in the lab datapath.

---
 rtl/pipelined_addsub.sv | 208 ++++++++++++++++++++
 tb/tb_pipelined_addsub.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined N-bit add/subtract unit with valid/ready handshakes on both sides.
// The carry chain is split into STAGES ripple segments of W = N/STAGES bits.
// Each segment lives in its own register stage, so the longest combinational
// path is one W-bit ripple plus handshake logic, never the full N-bit chain.
//
// Arithmetic (B' = Sub ? ~B : B, Cin' = Sub ? ~Cin : Cin):
//   {Cout, Sum} = A + B' + Cin'
//   Sub=0 -> A + B + Cin, Sub=1 -> A - B - Cin (mod 2^N), Cout=1 means no borrow
//   Ovf  = (A[N-1] == B'[N-1]) && (Sum[N-1] != A[N-1])
//   Zero = (Sum == 0)
//
// Data movement per beat: stage k consumes the lowest W bits of the operand
// slices it receives, forwards the still-unconsumed upper slices, appends its
// W result bits above the result bits already completed, and registers its
// carry-out for stage k+1. The last stage registers the full result and flags.
//
// Flow control: a single advance enable en = !out_valid | out_ready moves the
// whole pipeline in lockstep. in_ready = en. Bubbles are carried, not squeezed.
// Latency is STAGES cycles: a beat presented in cycle c (and accepted at the
// edge ending it) is visible on out_valid/Sum in cycle c+STAGES when unstalled.
//
// Parameters:
//   N       operand / result width, N >= 2
//   STAGES  pipeline depth (= latency), 1 <= STAGES <= N, N % STAGES == 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (dominates all handshake inputs)
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle (combinational from en)
//   A, B       operands
//   Cin        carry-in (add) / borrow-in (subtract)
//   Sub        0 = add, 1 = subtract
//   out_valid  result beat valid
//   out_ready  consumer accepts the result this cycle
//   Sum        result
//   Cout       carry-out of bit N-1 (subtract: 1 = no borrow)
//   Ovf        two's-complement signed overflow
//   Zero       Sum == 0
// ---------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         Zero
);

  // -------------------------------------------------------------------------
  // Parameter legality: refuse to elaborate a configuration that cannot be
  // split into equal segments.
  // -------------------------------------------------------------------------
  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: illegal parameters N=%0d STAGES=%0d", N, STAGES);
  end

  localparam int W    = N / STAGES;  // segment width
  localparam int LAST = STAGES - 1;  // index of the output stage

  // -------------------------------------------------------------------------
  // Global advance enable. Every stage register, payload and valid alike,
  // loads only when en is high, so a stall freezes the whole pipeline.
  // -------------------------------------------------------------------------
  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // -------------------------------------------------------------------------
  // Segment stages
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OW = N - k * W;    // operand bits still to be added here
    localparam int SW = (k + 1) * W;  // result bits complete after this stage

    // Stage inputs (from the ports for stage 0, else from stage k-1)
    logic          v_d;
    logic          c_d;
    logic [OW-1:0] a_d;
    logic [OW-1:0] b_d;

    // Stage arithmetic
    logic [W:0]    seg;   // {carry-out, W result bits} of this segment
    logic [SW-1:0] s_nx;  // completed result bits including this segment

    // Stage registers
    logic          v_q;
    logic          c_q;
    logic [SW-1:0] s_q;

    if (k == 0) begin : g_head
      // Subtraction is folded in once at the entry; later stages only add.
      assign v_d  = in_valid;
      assign a_d  = A;
      assign b_d  = Sub ? ~B : B;
      assign c_d  = Sub ? ~Cin : Cin;
      assign s_nx = seg[W-1:0];
    end else begin : g_body
      assign v_d  = g_stage[k-1].v_q;
      assign a_d  = g_stage[k-1].g_ops.a_q;
      assign b_d  = g_stage[k-1].g_ops.b_q;
      assign c_d  = g_stage[k-1].c_q;
      assign s_nx = {seg[W-1:0], g_stage[k-1].s_q};
    end

    // The only carry path of the stage: a W-bit ripple seeded by the
    // registered carry of the previous segment.
    assign seg = {1'b0, a_d[W-1:0]} + {1'b0, b_d[W-1:0]} + {{W{1'b0}}, c_d};

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would let a beat
    // fall through several stages in a single clock.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= seg[W];
        s_q <= s_nx;
      end
    end

    // Unconsumed operand slices travel with the beat. The last stage has
    // nothing left to forward, so it carries no operand registers.
    if (k < LAST) begin : g_ops
      logic [OW-W-1:0] a_q;
      logic [OW-W-1:0] b_q;

      // NOTE: payload registers are cleared by reset too, not only the valid
      // bits, so no output or internal value is ever X after reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d[OW-1:W];
          b_q <= b_d[OW-1:W];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result flags, registered alongside the last segment.
  // In the last stage the top operand slice sits at the low end of a_d/b_d,
  // so bit W-1 of each is the operand sign bit (A[N-1] and B'[N-1]).
  // -------------------------------------------------------------------------
  logic a_sign;
  logic b_sign;
  logic s_sign;
  logic ovf_q;
  logic zero_q;

  assign a_sign = g_stage[LAST].a_d[W-1];
  assign b_sign = g_stage[LAST].b_d[W-1];
  assign s_sign = g_stage[LAST].s_nx[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      ovf_q  <= (a_sign == b_sign) && (s_sign != a_sign);
      zero_q <= (g_stage[LAST].s_nx == '0);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: straight from the last stage registers
  // -------------------------------------------------------------------------
  assign out_valid = g_stage[LAST].v_q;
  assign Sum       = g_stage[LAST].s_q;
  assign Cout      = g_stage[LAST].c_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

  // -------------------------------------------------------------------------
  // Protocol checks: a result offered but not taken must stay put.
  // -------------------------------------------------------------------------
  a_hold_while_stalled : assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=>
        (out_valid && $stable(Sum) && $stable(Cout) && $stable(Ovf) && $stable(Zero))
  );

  a_ready_matches_enable : assert property (
    @(posedge clk) disable iff (!rst_n)
      in_ready == (!out_valid || out_ready)
  );

endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
module tb_pipelined_addsub;

  localparam int N      = 16;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: advances at each rising edge, read at falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, packed as {ovf, zero, cout, sum[31:0]} in bits [34:0].
  function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv, input logic sv, input int n);
    logic [63:0] mask;
    logic [63:0] bb;
    logic [63:0] full;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    mask = (64'd1 << n) - 64'd1;
    bb   = sv ? (~{32'd0, bv}) & mask : {32'd0, bv};
    full = {32'd0, av} + bb + {63'd0, (sv ? ~cv : cv)};
    s    = 32'(full & mask);
    co   = full[n];
    ov   = (av[n-1] == bb[n-1]) && (s[n-1] != av[n-1]);
    z    = (s == 32'd0);
    return {29'd0, ov, z, co, s};
  endfunction

  typedef struct {
    logic [63:0] res;
    int          cyc;
    int          stalls;
  } exp_t;

  // Reset for the sweep instances only; the main instance gets a mid-stream reset.
  logic rst_s;

  // -------------------------------------------------------------------------
  // Main instance (N=16, STAGES=4): directed tests
  // -------------------------------------------------------------------------
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  pipelined_addsub #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf), .Zero(zero)
  );

  // Scoreboard: push the model result on every accepted beat, pop and compare
  // on every consumed result. Latency is checked for beats that saw no stall.
  exp_t sb[$];
  exp_t sb_e;
  int   stalls = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("main_unexpected_beat", 64'd1, 64'd0);
        end else begin
          sb_e = sb.pop_front();
          check("main_result", {29'd0, ovf, zero, cout, 32'(sum)}, sb_e.res);
          if (stalls == sb_e.stalls) check("main_latency", 64'(cyc - sb_e.cyc), 64'(STAGES));
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready)
        sb.push_back('{model(32'(a), 32'(b), cin, sub, N), cyc, stalls});
    end
  end

  // Present one beat and hold it until accepted. Entered and left at posedge+1.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv, input logic sv);
    int k;
    k = 0;
    in_valid = 1'b1;
    a = av; b = bv; cin = cv; sub = sv;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) at falling edges until a result is offered.
  task automatic wait_out(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Sweep instances: random operands, random bubbles, random back-pressure
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int NN = (g == 1) ? 32 : 8;
    localparam int SS = (g == 0) ? 1 : 8;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [NN-1:0] s_a;
    logic [NN-1:0] s_b;
    logic          s_cin;
    logic          s_sub;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [NN-1:0] s_sum;
    logic          s_cout;
    logic          s_ovf;
    logic          s_zero;
    logic          done = 1'b0;

    exp_t q[$];
    exp_t e;
    int   s_stalls = 0;

    pipelined_addsub #(.N(NN), .STAGES(SS)) dut_s (
      .clk(clk), .rst_n(rst_s),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .A(s_a), .B(s_b), .Cin(s_cin), .Sub(s_sub),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .Sum(s_sum), .Cout(s_cout), .Ovf(s_ovf), .Zero(s_zero)
    );

    initial begin
      s_in_valid = 1'b0;
      s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      wait (rst_s);
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
        if (i % 50 == 0) begin
          s_a = '1; s_b = NN'(1); s_cin = 1'b0; s_sub = 1'b0;  // full carry ripple
        end else begin
          s_a = NN'($urandom); s_b = NN'($urandom);
          s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
        end
        s_in_valid = ($urandom_range(0, 4) != 0);
        if (s_in_valid) begin
          for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_in_ready) break;
          end
          if (!s_in_ready) check($sformatf("sweep%0d_send_timeout", g), 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
      end
      for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
      check($sformatf("sweep%0d_drained", g), 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    initial begin
      s_out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        s_out_ready = done ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end

    initial forever begin
      @(negedge clk);
      if (rst_s) begin
        if (s_out_valid && s_out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("sweep%0d_unexpected_beat", g), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("sweep%0d_result", g),
                  {29'd0, s_ovf, s_zero, s_cout, 32'(s_sum)}, e.res);
            if (s_stalls == e.stalls)
              check($sformatf("sweep%0d_latency", g), 64'(cyc - e.cyc), 64'(SS));
          end
        end
        if (s_out_valid && !s_out_ready) s_stalls++;
        if (s_in_valid && s_in_ready)
          q.push_back('{model(32'(s_a), 32'(s_b), s_cin, s_sub, NN), cyc, s_stalls});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed sequence on the main instance
  // -------------------------------------------------------------------------
  logic [N-1:0] held;
  logic         all_done;

  initial begin
    rst_n = 1'b0; rst_s = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rst_s = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Carry through every segment
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out("add_ripple");
    check("add_ripple_sum", 64'(sum), 64'h0000);
    check("add_ripple_cout", 64'(cout), 64'd1);
    check("add_ripple_zero", 64'(zero), 64'd1);
    check("add_ripple_ovf", 64'(ovf), 64'd0);
    idle(1);

    // Subtract with signed overflow
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_out("sub_ovf");
    check("sub_ovf_sum", 64'(sum), 64'h7FFF);
    check("sub_ovf_cout", 64'(cout), 64'd1);
    check("sub_ovf_ovf", 64'(ovf), 64'd1);
    check("sub_ovf_zero", 64'(zero), 64'd0);
    idle(1);

    // Subtract with borrow-in and borrow-out
    send(16'h0003, 16'h0005, 1'b1, 1'b1);
    wait_out("sub_borrow");
    check("sub_borrow_sum", 64'(sum), 64'hFFFD);
    check("sub_borrow_cout", 64'(cout), 64'd0);
    check("sub_borrow_ovf", 64'(ovf), 64'd0);
    idle(1);

    // Streaming: 8 back-to-back adds, scoreboard checks order and latency
    for (int i = 0; i < 8; i++)
      send(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    idle(10);
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Back-pressure: fill, stall for 3 cycles with a 5th beat waiting
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0010, 16'h0020, 1'b1, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    held = 16'h2345;
    fork
      send(16'h0F0F, 16'h00F0, 1'b0, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_out_valid", 64'(out_valid), 64'd1);
          check("bp_sum_hold", 64'(sum), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(12);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with 3 beats in flight
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0);
    send(16'h0505, 16'h0606, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(16'h4000, 16'h4000, 1'b0, 1'b0);
    idle(8);
    check("postrst_drained", 64'(sb.size()), 64'd0);

    // Wait for the parameter sweep
    all_done = 1'b0;
    for (int k = 0; k < 20000 && !all_done; k++) begin
      @(posedge clk);
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done;
    end
    check("sweep_finished", 64'(all_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
